regfile_wb_ctrl: RTL and testbench
==================================

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers swept at init.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter DATA_W, default 32, register data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alu_wr_valid / alu_wr_ready  input / output  1 / 1  ALU writeback handshake.
REQ-007 alu_wr_dest / alu_wr_data  input  ADDR_W / DATA_W  ALU writeback target and value.
REQ-008 mem_wr_valid / mem_wr_ready  input / output  1 / 1  load writeback handshake.
REQ-009 mem_wr_dest / mem_wr_data  input  ADDR_W / DATA_W  load writeback target and value.
REQ-010 reg_write_en  output  1  register-file write strobe.
REQ-011 reg_write_dest / reg_write_data  output  ADDR_W / DATA_W  register-file write port.
REQ-012 init_done  output  1  high once the controller is in RUN.
REQ-013 stall_cnt  output  16  saturating count of requester stall cycles.

Function
REQ-014 FSM states: ST_INIT, ST_RUN; transfer on a port occurs when valid and ready are both high at a rising edge.
REQ-015 ST_INIT: counter idx steps 0..NUM_REGS-1, one per cycle; registered outputs reg_write_en=1, dest=idx, data=0.
REQ-016 ST_INIT -> ST_RUN at the edge after idx=NUM_REGS-1 is issued; init_done rises in the same edge; total NUM_REGS write cycles.
REQ-017 Both ready outputs low in ST_INIT.
REQ-018 ST_RUN, one valid: that port's ready high combinationally, other ready low.
REQ-019 ST_RUN, both valid: grant goes to the port not granted last (round-robin); after reset the ALU wins the first tie.
REQ-020 Last-grant pointer updates only on an accepted transfer.
REQ-021 Write-port outputs are registered: reg_write_en/dest/data reflect a transfer at the edge after acceptance (latency 1 cycle); reg_write_en=0 in cycles with no transfer.
REQ-022 Transfer with dest=0 is accepted (ready high) but produces reg_write_en=0.
REQ-023 Back-to-back transfers sustain one write per cycle; same-dest writes retire in grant order.
REQ-024 stall_cnt increments by 1 per cycle in ST_RUN per port with valid high and ready low (at most +1 per cycle); saturates at 16'hFFFF.
REQ-025 Valid seen during ST_INIT does not count toward stall_cnt.

Reset
REQ-026 Reset asserted, including mid-sweep or mid-transfer, immediately forces: state ST_INIT (or ST_RUN, see REQ-030), idx=0, reg_write_en=0, dest=0, data=0, init_done=0, both readies 0, stall_cnt=0, last-grant=MEM.
REQ-027 An in-flight write registered before reset is discarded; no write strobe during reset.

Configuration
REQ-028 Macro REGFILE_INIT_EN selects the zeroing sweep.
REQ-029 With REGFILE_INIT_EN defined: reset exit enters ST_INIT and the REQ-015..017 behaviour applies.
REQ-030 Without it: reset exit enters ST_RUN directly, init_done=1 on the first edge after reset deasserts, no sweep writes are issued.

Structure
REQ-031 Shared package regfile_pkg holds ADDR_W/DATA_W defaults, NUM_REGS, the state enum {ST_INIT, ST_RUN} and requester-id enum {REQ_ALU, REQ_MEM}.
REQ-032 Sub-module rr_arbiter2 implements the two-way round-robin grant and last-grant pointer; FSM, sweep counter, output registers and stall counter live in the top.

Verification
REQ-033 Reset release (INIT_EN on) -> 32 cycles of reg_write_en=1, dest 0..31, data 0; init_done high after dest=31; readies low throughout.
REQ-034 RUN, ALU only valid, dest=5, data=0xDEADBEEF -> alu_wr_ready=1; next cycle reg_write_en=1, dest=5, data=0xDEADBEEF.
REQ-035 RUN, both valid for 4 cycles (ALU dest 3, MEM dest 4) -> grants ALU, MEM, ALU, MEM; stall_cnt=4.
REQ-036 RUN, MEM valid dest=0 data=0x1234 -> mem_wr_ready=1; next cycle reg_write_en=0.
REQ-037 Reset asserted at sweep idx=10 -> outputs zero immediately; after release sweep restarts at dest 0.
REQ-038 Both valid held 70000 cycles -> stall_cnt saturates at 0xFFFF; build without REGFILE_INIT_EN -> init_done=1 one cycle after reset release, no sweep writes.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file writeback controller.
package regfile_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter between ALU and load writeback requesters.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu,
  output logic gnt_mem
);

  req_e last_q, last_d;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_mem = 1'b0;
    if (enable) begin
      if (req_alu && req_mem) begin
        // Tie goes to whichever side did not win the previous transfer.
        if (last_q == REQ_MEM) gnt_alu = 1'b1;
        else                   gnt_mem = 1'b1;
      end else begin
        gnt_alu = req_alu;
        gnt_mem = req_mem;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_alu)      last_d = REQ_ALU;
    else if (gnt_mem) last_d = REQ_MEM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= REQ_MEM;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load writebacks into one register-file write port.
// Define REGFILE_INIT_EN to zero all registers with a sweep after reset.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_wr_valid,
  output logic              alu_wr_ready,
  input  logic [ADDR_W-1:0] alu_wr_dest,
  input  logic [DATA_W-1:0] alu_wr_data,
  input  logic              mem_wr_valid,
  output logic              mem_wr_ready,
  input  logic [ADDR_W-1:0] mem_wr_dest,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              init_done,
  output logic [15:0]       stall_cnt
);

`ifdef REGFILE_INIT_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_RUN;
`endif
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              init_done_q, init_done_d;
  logic [15:0]       stall_q, stall_d;

  logic run;
  logic gnt_alu, gnt_mem;
  logic stall_any;

  // init_done_q gates RUN so that the no-sweep build still holds off one edge after reset.
  assign run = (state_q == ST_RUN) && init_done_q;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .enable  (run),
    .req_alu (alu_wr_valid),
    .req_mem (mem_wr_valid),
    .gnt_alu (gnt_alu),
    .gnt_mem (gnt_mem)
  );

  assign alu_wr_ready = gnt_alu;
  assign mem_wr_ready = gnt_mem;
  assign stall_any    = (alu_wr_valid && !gnt_alu) || (mem_wr_valid && !gnt_mem);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = 1'b0;
    dest_d      = dest_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    stall_d     = stall_q;
    case (state_q)
      ST_INIT: begin
        we_d   = 1'b1;
        dest_d = idx_q;
        data_d = '0;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
        if (gnt_alu) begin
          we_d   = |alu_wr_dest;
          dest_d = alu_wr_dest;
          data_d = alu_wr_data;
        end else if (gnt_mem) begin
          we_d   = |mem_wr_dest;
          dest_d = mem_wr_dest;
          data_d = mem_wr_data;
        end
        if (init_done_q && stall_any && (stall_q != 16'hFFFF))
          stall_d = stall_q + 16'd1;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      idx_q       <= '0;
      we_q        <= 1'b0;
      dest_q      <= '0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      dest_q      <= dest_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      stall_q     <= stall_d;
    end
  end

  assign reg_write_en   = we_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;
  assign init_done      = init_done_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed, table-driven bench for regfile_wb_ctrl; sweep checks apply when REGFILE_INIT_EN is defined.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        reset;
  logic        alu_wr_valid, alu_wr_ready;
  logic [4:0]  alu_wr_dest;
  logic [31:0] alu_wr_data;
  logic        mem_wr_valid, mem_wr_ready;
  logic [4:0]  mem_wr_dest;
  logic [31:0] mem_wr_data;
  logic        reg_write_en;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_data;
  logic        init_done;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  regfile_wb_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .alu_wr_valid   (alu_wr_valid),
    .alu_wr_ready   (alu_wr_ready),
    .alu_wr_dest    (alu_wr_dest),
    .alu_wr_data    (alu_wr_data),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_ready   (mem_wr_ready),
    .mem_wr_dest    (mem_wr_dest),
    .mem_wr_data    (mem_wr_data),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .init_done      (init_done),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mdata;
    logic        ea;
    logic        em;
    logic        ewe;
    logic [4:0]  ed;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_wr_valid = 1'b0;
    alu_wr_dest  = '0;
    alu_wr_data  = '0;
    mem_wr_valid = 1'b0;
    mem_wr_dest  = '0;
    mem_wr_data  = '0;
  endtask

  task automatic check_zeroed(input string tag);
    chk({tag, "_we"},   {31'd0, reg_write_en}, 32'd0);
    chk({tag, "_dest"}, {27'd0, reg_write_dest}, 32'd0);
    chk({tag, "_data"}, reg_write_data, 32'd0);
    chk({tag, "_init"}, {31'd0, init_done}, 32'd0);
    chk({tag, "_stall"}, {16'd0, stall_cnt}, 32'd0);
    chk({tag, "_ardy"}, {31'd0, alu_wr_ready}, 32'd0);
    chk({tag, "_mrdy"}, {31'd0, mem_wr_ready}, 32'd0);
  endtask

  // Returns at the falling edge right after reset is released.
  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    #1;
    check_zeroed("rst");
    @(posedge clk);
    #1;
    chk("rst_hold_we", {31'd0, reg_write_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts right after reset release; ends on a falling edge with init_done high.
  task automatic init_seq();
`ifdef REGFILE_INIT_EN
    alu_wr_valid = 1'b1;
    alu_wr_dest  = 5'd9;
    alu_wr_data  = 32'h9999_9999;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("sweep_we",   {31'd0, reg_write_en}, 32'd1);
      chk("sweep_dest", {27'd0, reg_write_dest}, k);
      chk("sweep_data", reg_write_data, 32'd0);
      chk("sweep_init", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
      chk("sweep_stall", {16'd0, stall_cnt}, 32'd0);
      if (k < 31) begin
        chk("sweep_ardy", {31'd0, alu_wr_ready}, 32'd0);
        chk("sweep_mrdy", {31'd0, mem_wr_ready}, 32'd0);
      end
      if (k == 30) drive_idle();
    end
    $display("sweep complete init_done=%b", init_done);
`else
    mem_wr_valid = 1'b1;
    mem_wr_dest  = 5'd2;
    #1;
    chk("pre_run_init", {31'd0, init_done}, 32'd0);
    chk("pre_run_mrdy", {31'd0, mem_wr_ready}, 32'd0);
    drive_idle();
    @(negedge clk);
    chk("run_init", {31'd0, init_done}, 32'd1);
    chk("run_no_sweep_we", {31'd0, reg_write_en}, 32'd0);
    chk("run_stall0", {16'd0, stall_cnt}, 32'd0);
    $display("direct run init_done=%b we=%b", init_done, reg_write_en);
`endif
  endtask

  task automatic check_write(input int i, input string tag);
    chk({tag, "_we"}, {31'd0, reg_write_en}, {31'd0, vecs[i].ewe});
    if (vecs[i].ewe) begin
      chk({tag, "_dest"}, {27'd0, reg_write_dest}, {27'd0, vecs[i].ed});
      chk({tag, "_data"}, reg_write_data, vecs[i].edata);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd3,  32'h33,        1'b1, 5'd4,  32'h44,        1'b1, 1'b0, 1'b1, 5'd3,  32'h33};
    vecs[1]  = '{1'b1, 5'd3,  32'h33,        1'b1, 5'd4,  32'h44,        1'b0, 1'b1, 1'b1, 5'd4,  32'h44};
    vecs[2]  = '{1'b1, 5'd3,  32'h33,        1'b1, 5'd4,  32'h44,        1'b1, 1'b0, 1'b1, 5'd3,  32'h33};
    vecs[3]  = '{1'b1, 5'd3,  32'h33,        1'b1, 5'd4,  32'h44,        1'b0, 1'b1, 1'b1, 5'd4,  32'h44};
    vecs[4]  = '{1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h1234,      1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h77,        1'b0, 1'b1, 1'b1, 5'd7,  32'h77};
    vecs[8]  = '{1'b1, 5'd9,  32'h99,        1'b1, 5'd10, 32'hAA,        1'b1, 1'b0, 1'b1, 5'd9,  32'h99};
    vecs[9]  = '{1'b1, 5'd12, 32'h1,         1'b1, 5'd12, 32'h2,         1'b0, 1'b1, 1'b1, 5'd12, 32'h2};
    vecs[10] = '{1'b1, 5'd12, 32'h3,         1'b0, 5'd0,  32'h0,         1'b1, 1'b0, 1'b1, 5'd12, 32'h3};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 32'hFFFFFFFF,  1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};

    drive_idle();
    reset = 1'b1;

    apply_reset();
    init_seq();
    @(posedge clk);
    #1;
    chk("run_stall_start", {16'd0, stall_cnt}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      alu_wr_valid = vecs[i].av;
      alu_wr_dest  = vecs[i].ad;
      alu_wr_data  = vecs[i].adata;
      mem_wr_valid = vecs[i].mv;
      mem_wr_dest  = vecs[i].md;
      mem_wr_data  = vecs[i].mdata;
      @(negedge clk);
      chk("vec_ardy", {31'd0, alu_wr_ready}, {31'd0, vecs[i].ea});
      chk("vec_mrdy", {31'd0, mem_wr_ready}, {31'd0, vecs[i].em});
      if (i > 0) check_write(i - 1, "vec_wr");
      if (i == 4) chk("vec_stall4", {16'd0, stall_cnt}, 32'd4);
      $display("vec %0d alu_rdy=%b mem_rdy=%b we=%b dest=%0d data=%h stall=%0d",
               i, alu_wr_ready, mem_wr_ready, reg_write_en, reg_write_dest, reg_write_data, stall_cnt);
      @(posedge clk);
      #1;
    end
    drive_idle();
    @(negedge clk);
    check_write(11, "vec_wr_last");
    chk("vec_stall_end", {16'd0, stall_cnt}, 32'd6);
    @(negedge clk);
    chk("idle_we", {31'd0, reg_write_en}, 32'd0);
    $display("table done stall=%0d", stall_cnt);

    // Reset landing on an in-flight write must drop it at once.
    @(posedge clk);
    #1;
    alu_wr_valid = 1'b1;
    alu_wr_dest  = 5'd6;
    alu_wr_data  = 32'h66;
    @(posedge clk);
    #1;
    chk("inflight_we",   {31'd0, reg_write_en}, 32'd1);
    chk("inflight_dest", {27'd0, reg_write_dest}, 32'd6);
    #2;
    reset = 1'b1;
    #1;
    check_zeroed("midxfer_rst");
    $display("reset during transfer we=%b ardy=%b", reg_write_en, alu_wr_ready);
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    init_seq();

`ifdef REGFILE_INIT_EN
    apply_reset();
    repeat (11) @(negedge clk);
    chk("midsweep_dest10", {27'd0, reg_write_dest}, 32'd10);
    #2;
    reset = 1'b1;
    #1;
    check_zeroed("midsweep_rst");
    $display("reset at sweep idx 10 we=%b dest=%0d", reg_write_en, reg_write_dest);
    @(negedge clk);
    reset = 1'b0;
    init_seq();
`endif

    // Saturation: one requester stalls on every cycle of a sustained tie.
    @(posedge clk);
    #1;
    alu_wr_valid = 1'b1;
    alu_wr_dest  = 5'd1;
    alu_wr_data  = 32'h11;
    mem_wr_valid = 1'b1;
    mem_wr_dest  = 5'd2;
    mem_wr_data  = 32'h22;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat_we", {31'd0, reg_write_en}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
    $display("saturation stall=%h", stall_cnt);
    drive_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
